rom_loader: RTL



---
 rtl/rom_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rom_loader: streams a length-prefixed little-endian program image into the instruction ROM and holds the core in reset until it has loaded.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum-of-data-bytes check before release.
module rom_loader #(
  parameter int ADDR_W = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  input  logic              start_i,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_waddr_o,
  output logic [31:0]       rom_wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);
`ifdef ROM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN, DATA, CKSUM, DONE, ERR} state_t;
  logic [7:0] sum;
`else
  typedef enum logic [2:0] {LEN, DATA, DONE, ERR} state_t;
`endif
  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;
  state_t state;
  logic [1:0] bcnt;
  logic [31:0] len;
  logic [23:0] sh;
  logic acc;
  logic [31:0] nxt_len, nxt_word;
  assign acc = byte_valid_i & byte_ready_o;
  assign nxt_len = {byte_i, len[31:8]};
  assign nxt_word = {byte_i, sh};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= LEN;
      bcnt <= '0;
      len <= '0;
      sh <= '0;
      byte_ready_o <= 1'b0;
      rom_we_o <= 1'b0;
      rom_waddr_o <= ADDR_W'(BASE_ADDR);
      rom_wdata_o <= '0;
      core_rst_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      words_o <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      rom_we_o <= 1'b0;
      case (state)
        LEN: begin
          byte_ready_o <= 1'b1;
          if (acc) begin
            len <= nxt_len;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              if (nxt_len == '0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                state <= CKSUM;
`else
                state <= DONE;
                byte_ready_o <= 1'b0;
`endif
              end else if ({1'b0, nxt_len} > DEPTH) begin
                state <= ERR;
                err_o <= 1'b1;
                byte_ready_o <= 1'b0;
              end else state <= DATA;
            end
          end
        end
        DATA: if (acc) begin
          sh <= nxt_word[31:8];
          bcnt <= bcnt + 2'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
          sum <= sum + byte_i;
`endif
          if (bcnt == 2'd3) begin
            rom_we_o <= 1'b1;
            rom_wdata_o <= nxt_word;
            rom_waddr_o <= ADDR_W'(BASE_ADDR) + words_o[ADDR_W-1:0];
            words_o <= words_o + 1'b1;
            if (32'(words_o) + 32'd1 == len) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              state <= CKSUM;
`else
              state <= DONE;
              byte_ready_o <= 1'b0;
`endif
            end
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        CKSUM: if (acc) begin
          byte_ready_o <= 1'b0;
          state <= (byte_i == sum) ? DONE : ERR;
          err_o <= (byte_i != sum);
        end
`endif
        DONE, ERR: if (start_i) begin
          state <= LEN;
          byte_ready_o <= 1'b1;
          bcnt <= '0;
          done_o <= 1'b0;
          err_o <= 1'b0;
          core_rst_o <= 1'b0;
          words_o <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
          sum <= '0;
`endif
        end else if (state == DONE) begin
          done_o <= 1'b1;
          core_rst_o <= 1'b1;
        end
        default: state <= LEN;
      endcase
    end
endmodule
